// File: rtl/dmem_arbiter_ctrl.sv
// dmem_arbiter_ctrl: round-robin two-requester arbiter and access sequencer for a 64-bit single-port data memory
// Ports: clk/rst_n clock and async active-low reset; req_* per-requester load/store requests (packed [i*64 +: 64]);
// rsp_* one-cycle response pulse, formatted load data and fault flag; mem_* synchronous memory port (read data next cycle).
module dmem_arbiter_ctrl #(
    parameter int DMEM_DEPTH = 1024,
    parameter int IDX_W      = $clog2(DMEM_DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [1:0]       req_we,
    input  logic [127:0]     req_addr,
    input  logic [127:0]     req_wdata,
    input  logic [3:0]       req_size,
    input  logic [1:0]       req_unsigned,
    output logic [1:0]       rsp_valid,
    output logic [63:0]      rsp_rdata,
    output logic             rsp_err,
    output logic             mem_en,
    output logic             mem_we,
    output logic [IDX_W-1:0] mem_addr,
    output logic [63:0]      mem_wdata,
    output logic [7:0]       mem_wstrb,
    input  logic [63:0]      mem_rdata
);
    typedef enum logic [1:0] {IDLE, ISSUE, RDATA, RESP} state_t;
    state_t      state;
    logic        last_grant, id, we, uns, gid, g_we, g_uns, err;
    logic [1:0]  size, sz;
    logic [2:0]  off;
    logic [7:0]  mask;
    logic [63:0] a, wd, sh, fmt;
    // on a tie the requester that did not win last time is granted
    assign gid   = &req_valid ? ~last_grant : req_valid[1];
    assign req_ready = (state == IDLE && rst_n) ? {gid, ~gid} & req_valid : 2'b00;
    assign a     = gid ? req_addr[127:64]  : req_addr[63:0];
    assign wd    = gid ? req_wdata[127:64] : req_wdata[63:0];
    assign sz    = gid ? req_size[3:2]     : req_size[1:0];
    assign g_we  = gid ? req_we[1]         : req_we[0];
    assign g_uns = gid ? req_unsigned[1]   : req_unsigned[0];
    assign err   = (sz == 2'd1 && a[0]) || (sz == 2'd2 && |a[1:0]) || (sz == 2'd3 && |a[2:0]) ||
                   a[63:3] >= 61'(DMEM_DEPTH);
    assign mask  = sz == 2'd0 ? 8'h01 : sz == 2'd1 ? 8'h03 : sz == 2'd2 ? 8'h0F : 8'hFF;
    assign sh    = mem_rdata >> {off, 3'b000};
    assign fmt   = size == 2'd0 ? {{56{~uns & sh[7]}},  sh[7:0]}  :
                   size == 2'd1 ? {{48{~uns & sh[15]}}, sh[15:0]} :
                   size == 2'd2 ? {{32{~uns & sh[31]}}, sh[31:0]} : sh;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            id         <= 1'b0;
            we         <= 1'b0;
            uns        <= 1'b0;
            size       <= 2'd0;
            off        <= 3'd0;
            rsp_valid  <= 2'b00;
            rsp_rdata  <= '0;
            rsp_err    <= 1'b0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_wstrb  <= 8'h00;
        end else begin
            case (state)
                IDLE: if (|req_valid) begin
                    id         <= gid;
                    last_grant <= gid;
                    we         <= g_we;
                    uns        <= g_uns;
                    size       <= sz;
                    off        <= a[2:0];
                    if (err) begin
                        state     <= RESP;
                        rsp_valid <= {gid, ~gid};
                        rsp_err   <= 1'b1;
                    end else begin
                        state     <= ISSUE;
                        mem_en    <= 1'b1;
                        mem_we    <= g_we;
                        mem_addr  <= a[IDX_W+2:3];
                        mem_wstrb <= g_we ? mask << a[2:0] : 8'h00;
                        mem_wdata <= g_we ? wd << {a[2:0], 3'b000} : '0;
                    end
                end
                ISSUE: begin
                    mem_en    <= 1'b0;
                    mem_we    <= 1'b0;
                    mem_addr  <= '0;
                    mem_wdata <= '0;
                    mem_wstrb <= 8'h00;
                    state     <= we ? RESP : RDATA;
                    rsp_valid <= we ? {id, ~id} : 2'b00;
                end
                RDATA: begin
                    state     <= RESP;
                    rsp_valid <= {id, ~id};
                    rsp_rdata <= fmt;
                end
                RESP: begin
                    state     <= IDLE;
                    rsp_valid <= 2'b00;
                    rsp_rdata <= '0;
                    rsp_err   <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_arbiter_ctrl.sv
// tb_dmem_arbiter_ctrl: directed self-checking bench for dmem_arbiter_ctrl with a behavioural memory
module tb_dmem_arbiter_ctrl;
    logic         clk = 0, rst_n = 0, init = 1;
    logic [1:0]   req_valid = 0, req_ready, req_we = 0, req_unsigned = 0, rsp_valid;
    logic [127:0] req_addr = 0, req_wdata = 0;
    logic [3:0]   req_size = 0;
    logic [63:0]  rsp_rdata, mem_wdata, mem_rdata = 0;
    logic         rsp_err, mem_en, mem_we;
    logic [9:0]   mem_addr;
    logic [7:0]   mem_wstrb;
    logic [63:0]  mem [0:1023];
    int           errs = 0, checks = 0, en_cnt = 0;
    logic         cap_en;
    logic [9:0]   cap_addr;
    logic [7:0]   cap_strb;
    logic [63:0]  cap_wdata;
    int           lat;
    logic [1:0]   rv;
    logic [63:0]  rd;
    logic         e;

    dmem_arbiter_ctrl dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size), .req_unsigned(req_unsigned),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .mem_en(mem_en), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (init) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 64'h0;
            mem[0] <= 64'hDEADBEEF_DEADBEEF;
        end else if (mem_en) begin
            en_cnt++;
            if (mem_we) begin
                for (int b = 0; b < 8; b++)
                    if (mem_wstrb[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            end else
                mem_rdata <= mem[mem_addr];
        end
    end

    task automatic drive(input int id, input logic w, input logic [63:0] addr, input logic [63:0] wdata,
                         input logic [1:0] sz, input logic u);
        req_we[id]             = w;
        req_addr[id*64 +: 64]  = addr;
        req_wdata[id*64 +: 64] = wdata;
        req_size[id*2 +: 2]    = sz;
        req_unsigned[id]       = u;
        req_valid[id]          = 1'b1;
    endtask

    // issues one request, returns response latency (cycles after acceptance) and the response fields
    task automatic transact(input int id, input logic w, input logic [63:0] addr, input logic [63:0] wdata,
                            input logic [1:0] sz, input logic u);
        bit got = 0;
        cap_en = 0; lat = 99; rv = 0; rd = 0; e = 0;
        @(negedge clk);
        drive(id, w, addr, wdata, sz, u);
        #1;
        for (int k = 0; k < 20 && !got; k++) begin
            if (req_ready[id]) got = 1;
            else begin @(negedge clk); #1; end
        end
        if (!got) begin
            checks++; errs++;
            $display("FAIL accept_timeout: req_ready=%b required bit %0d", req_ready, id);
            req_valid[id] = 1'b0;
            return;
        end
        @(posedge clk); #1;
        req_valid[id] = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (mem_en) begin cap_en = 1; cap_addr = mem_addr; cap_strb = mem_wstrb; cap_wdata = mem_wdata; end
            if (|rsp_valid) begin lat = k; rv = rsp_valid; rd = rsp_rdata; e = rsp_err; break; end
        end
    endtask

    task automatic test_reset;
        req_valid = 2'b11;
        @(negedge clk);
        checks++;
        if ({req_ready, rsp_valid, rsp_err, mem_en, mem_we, mem_wstrb} !== 15'h0) begin
            errs++; $display("FAIL reset_ctrl: got %h required 0", {req_ready, rsp_valid, rsp_err, mem_en, mem_we, mem_wstrb});
        end
        checks++;
        if ({rsp_rdata, mem_wdata, mem_addr} !== 138'h0) begin
            errs++; $display("FAIL reset_data: rdata=%h wdata=%h addr=%h required 0", rsp_rdata, mem_wdata, mem_addr);
        end
        req_valid = 2'b00;
        init = 0;
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_load;
        transact(0, 0, 64'h0, 64'h0, 2'd3, 0);
        checks++; if (lat !== 3) begin errs++; $display("FAIL ld_latency: got %0d required 3", lat); end
        checks++; if (rv !== 2'b01) begin errs++; $display("FAIL ld_route: got %b required 01", rv); end
        checks++; if (rd !== 64'hDEADBEEF_DEADBEEF) begin errs++; $display("FAIL ld_data: got %h required deadbeefdeadbeef", rd); end
        checks++; if (e !== 1'b0) begin errs++; $display("FAIL ld_err: got %b required 0", e); end
    endtask

    task automatic test_load_ext;
        transact(0, 0, 64'h3, 64'h0, 2'd0, 0);
        checks++; if (rd !== 64'hFFFFFFFF_FFFFFFDE) begin errs++; $display("FAIL lb_data: got %h required ffffffffffffffde", rd); end
        transact(0, 0, 64'h3, 64'h0, 2'd0, 1);
        checks++; if (rd !== 64'h00000000_000000DE) begin errs++; $display("FAIL lbu_data: got %h required de", rd); end
        transact(0, 0, 64'h4, 64'h0, 2'd2, 1);
        checks++; if (rd !== 64'h00000000_DEADBEEF) begin errs++; $display("FAIL lwu_data: got %h required deadbeef", rd); end
        transact(0, 0, 64'h2, 64'h0, 2'd1, 0);
        checks++; if (rd !== 64'hFFFFFFFF_FFFFDEAD) begin errs++; $display("FAIL lh_data: got %h required ffffffffffffdead", rd); end
    endtask

    task automatic test_store;
        transact(1, 1, 64'hC, 64'h12345678, 2'd2, 0);
        checks++; if (lat !== 2) begin errs++; $display("FAIL sw_latency: got %0d required 2", lat); end
        checks++; if (rv !== 2'b10) begin errs++; $display("FAIL sw_route: got %b required 10", rv); end
        checks++; if (cap_addr !== 10'd1) begin errs++; $display("FAIL sw_addr: got %0d required 1", cap_addr); end
        checks++; if (cap_strb !== 8'hF0) begin errs++; $display("FAIL sw_strb: got %h required f0", cap_strb); end
        checks++; if (cap_wdata[63:32] !== 32'h12345678) begin errs++; $display("FAIL sw_wdata: got %h required 12345678", cap_wdata[63:32]); end
        checks++; if ({rd, e} !== 65'h0) begin errs++; $display("FAIL sw_rsp: rdata=%h err=%b required 0", rd, e); end
        transact(0, 0, 64'h8, 64'h0, 2'd3, 0);
        checks++; if (rd !== 64'h12345678_00000000) begin errs++; $display("FAIL sw_readback: got %h required 1234567800000000", rd); end
        transact(1, 1, 64'hF, 64'h55AB, 2'd0, 0);
        checks++; if (cap_strb !== 8'h80) begin errs++; $display("FAIL sb_strb: got %h required 80", cap_strb); end
        transact(1, 0, 64'h8, 64'h0, 2'd3, 0);
        checks++; if (rd !== 64'hAB345678_00000000) begin errs++; $display("FAIL sb_readback: got %h required ab34567800000000", rd); end
    endtask

    task automatic test_error;
        int n0 = en_cnt;
        transact(0, 0, 64'h6, 64'h0, 2'd2, 0);
        checks++; if ({lat, rv, e, rd} !== {32'd1, 2'b01, 1'b1, 64'h0})
            begin errs++; $display("FAIL misalign: lat=%0d rsp=%b err=%b rdata=%h required 1 01 1 0", lat, rv, e, rd); end
        transact(0, 0, 64'h2000, 64'h0, 2'd3, 0);
        checks++; if ({lat, rv, e, rd} !== {32'd1, 2'b01, 1'b1, 64'h0})
            begin errs++; $display("FAIL out_of_range: lat=%0d rsp=%b err=%b rdata=%h required 1 01 1 0", lat, rv, e, rd); end
        transact(1, 1, 64'h1FF8, 64'h77, 2'd3, 0);
        checks++; if ({lat, e} !== {32'd2, 1'b0}) begin errs++; $display("FAIL last_word: lat=%0d err=%b required 2 0", lat, e); end
        checks++; if (en_cnt !== n0 + 1) begin errs++; $display("FAIL err_no_mem_en: got %0d strobes required %0d", en_cnt - n0, 1); end
    endtask

    task automatic test_reset_mid;
        bit got = 0, seen = 0;
        @(negedge clk);
        drive(1, 1, 64'h10, 64'hAAAA, 2'd3, 0);
        #1;
        for (int k = 0; k < 20 && !got; k++) begin
            if (req_ready[1]) got = 1;
            else begin @(negedge clk); #1; end
        end
        @(posedge clk); #1;
        checks++; if (mem_en !== 1'b1) begin errs++; $display("FAIL mid_issue: mem_en=%b required 1", mem_en); end
        rst_n = 0;
        req_valid = 2'b11;
        #1;
        checks++;
        if ({req_ready, rsp_valid, rsp_err, mem_en, mem_we, mem_wstrb, mem_addr} !== 25'h0 || {rsp_rdata, mem_wdata} !== 128'h0) begin
            errs++; $display("FAIL mid_reset_outputs: en=%b we=%b strb=%h ready=%b rsp=%b required 0", mem_en, mem_we, mem_wstrb, req_ready, rsp_valid);
        end
        for (int k = 0; k < 3; k++) begin @(negedge clk); if (|rsp_valid) seen = 1; end
        checks++; if (seen) begin errs++; $display("FAIL mid_reset_rsp: got a response required none"); end
        checks++; if (mem[2] !== 64'h0) begin errs++; $display("FAIL mid_reset_write: got %h required 0", mem[2]); end
        req_valid = 2'b00;
        rst_n = 1;
    endtask

    task automatic test_arbitration;
        logic [1:0]  exp [4];
        logic [1:0]  g;
        bit          got;
        exp[0] = 2'b01; exp[1] = 2'b10; exp[2] = 2'b01; exp[3] = 2'b10;
        @(negedge clk);
        drive(0, 0, 64'h0, 64'h0, 2'd3, 0);
        drive(1, 0, 64'h8, 64'h0, 2'd3, 0);
        #1;
        for (int i = 0; i < 4; i++) begin
            got = 0;
            for (int k = 0; k < 20 && !got; k++) begin
                if (|req_ready) got = 1;
                else begin @(negedge clk); #1; end
            end
            g = req_ready;
            checks++; if (g !== exp[i]) begin errs++; $display("FAIL grant_%0d: got %b required %b", i, g, exp[i]); end
            @(posedge clk);
            @(negedge clk);
            checks++; if (req_ready !== 2'b00) begin errs++; $display("FAIL busy_ready_%0d: got %b required 00", i, req_ready); end
            got = 0;
            for (int k = 0; k < 10 && !got; k++) begin
                if (|rsp_valid) got = 1;
                else @(negedge clk);
            end
            checks++; if (rsp_valid !== g) begin errs++; $display("FAIL rsp_route_%0d: got %b required %b", i, rsp_valid, g); end
            checks++;
            if (rsp_rdata !== (g[0] ? 64'hDEADBEEF_DEADBEEF : 64'hAB345678_00000000)) begin
                errs++; $display("FAIL arb_data_%0d: got %h", i, rsp_rdata);
            end
            @(negedge clk); #1;
        end
        req_valid = 2'b00;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        test_reset;
        test_load;
        test_load_ext;
        test_store;
        test_error;
        test_reset_mid;
        test_arbitration;
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
